// File: rtl/data_mux_pipe.sv
// One-hot N_CH x W data mux with a single valid/ready register stage, select-error flag and beat counter.
// Optional registered even-parity output out_par when DATA_MUX_PIPE_PARITY_EN is defined.
module data_mux_pipe #(
  parameter int unsigned N_CH  = 5,
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*W-1:0]         in_data,
  input  logic [N_CH-1:0]           in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [W-1:0]              out_data,
  output logic [$clog2(N_CH)-1:0]   out_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err_onehot,
  input  logic                      err_clr,
  output logic [CNT_W-1:0]          beat_cnt
`ifdef DATA_MUX_PIPE_PARITY_EN
  ,
  output logic                      out_par
`endif
);

  localparam int unsigned IDX_W = $clog2(N_CH);

  logic [W-1:0]     data_q,  data_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             par_q,   par_d;

  logic [W-1:0]     sel_data;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             sel_bad;
  logic             accept;

  // OR of all selected channels; index is the lowest set select bit
  always_comb begin
    sel_data  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (in_sel[k]) begin
        sel_data = sel_data | in_data[k*W +: W];
        if (!sel_found) begin
          sel_idx   = IDX_W'(k);
          sel_found = 1'b1;
        end
      end
    end
    sel_bad = !$onehot(in_sel);
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    if (accept) begin
      data_d  = sel_data;
      idx_d   = sel_idx;
      valid_d = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
      par_d   = ^sel_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    // a bad beat in the same cycle as a clear leaves the flag set
    if (accept && sel_bad) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  assign out_data   = data_q;
  assign out_idx    = idx_q;
  assign out_valid  = valid_q;
  assign err_onehot = err_q;
  assign beat_cnt   = cnt_q;

`ifdef DATA_MUX_PIPE_PARITY_EN
  assign out_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

// File: tb/tb_data_mux_pipe.sv
// Directed bench for data_mux_pipe (N_CH=5, W=8, CNT_W=4) with a per-cycle reference model.
module tb_data_mux_pipe;
  localparam int unsigned N_CH  = 5;
  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              err_onehot;
  logic              err_clr;
  logic [CNT_W-1:0]  beat_cnt;
`ifdef DATA_MUX_PIPE_PARITY_EN
  logic              out_par;
`endif

  int errors = 0;
  int checks = 0;

  data_mux_pipe #(.N_CH(N_CH), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .err_onehot(err_onehot), .err_clr(err_clr), .beat_cnt(beat_cnt)
`ifdef DATA_MUX_PIPE_PARITY_EN
    , .out_par(out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs derived from the accept rules with plain arithmetic
  logic [W-1:0] m_data;
  int           m_idx;
  logic         m_valid;
  logic         m_err;
  int           m_cnt;

  function automatic logic [W-1:0] mux_or(input logic [N_CH*W-1:0] d, input logic [N_CH-1:0] s);
    logic [W-1:0] r = '0;
    for (int k = 0; k < int'(N_CH); k++)
      if (s[k]) r = r | W'(d >> (k*W));
    return r;
  endfunction

  function automatic int low_idx(input logic [N_CH-1:0] s);
    logic [N_CH-1:0] iso;
    iso = s & (~s + N_CH'(1));
    return (s == '0) ? 0 : $clog2(int'(iso));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data = '0; m_idx = 0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      logic acc;
      acc = in_valid && (!m_valid || out_ready);
      if (acc) begin
        m_data  = mux_or(in_data, in_sel);
        m_idx   = low_idx(in_sel);
        m_valid = 1'b1;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (acc && !$onehot(in_sel)) m_err = 1'b1;
      else if (err_clr)            m_err = 1'b0;
    end
  end

  // Compare DUT against the model on every falling edge outside reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_valid", 64'(out_valid), 64'(m_valid));
      chk("m_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      chk("m_err", 64'(err_onehot), 64'(m_err));
      chk("m_cnt", 64'(beat_cnt), 64'(m_cnt));
      if (m_valid) begin
        chk("m_data", 64'(out_data), 64'(m_data));
        chk("m_idx", 64'(out_idx), 64'(m_idx));
`ifdef DATA_MUX_PIPE_PARITY_EN
        chk("m_par", 64'(out_par), 64'(^m_data));
`endif
      end
    end
  end

  localparam logic [N_CH*W-1:0] CH_BASE = 40'h55_44_33_22_11;

  task automatic cyc(input logic v, input logic [N_CH-1:0] s, input logic r, input logic c);
    in_valid = v; in_sel = s; out_ready = r; err_clr = c;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_data = CH_BASE; in_sel = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // basic select of channel 3
    cyc(1'b1, 5'b01000, 1'b1, 1'b0);
    chk("basic_data", 64'(out_data), 64'h44);
    chk("basic_idx", 64'(out_idx), 64'd3);
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_cnt", 64'(beat_cnt), 64'd1);
    chk("basic_err", 64'(err_onehot), 64'd0);

    // backpressure: held beat must not change while upstream data moves
    for (int i = 0; i < 3; i++) begin
      in_data = CH_BASE ^ {N_CH{8'(8'hA0 + i)}};
      in_valid = 1'b1; in_sel = 5'b00010; out_ready = 1'b0; #1;
      chk("bp_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("bp_data", 64'(out_data), 64'h44);
      chk("bp_valid", 64'(out_valid), 64'd1);
    end
    in_data = CH_BASE;
    cyc(1'b1, 5'b00010, 1'b1, 1'b0);
    chk("bp_new_data", 64'(out_data), 64'h22);
    chk("bp_new_valid", 64'(out_valid), 64'd1);
    chk("bp_new_cnt", 64'(beat_cnt), 64'd2);

    // bad selects
    cyc(1'b1, 5'b00101, 1'b1, 1'b0);
    chk("multi_data", 64'(out_data), 64'h33);
    chk("multi_idx", 64'(out_idx), 64'd0);
    chk("multi_err", 64'(err_onehot), 64'd1);
    cyc(1'b1, 5'b00000, 1'b1, 1'b0);
    chk("zero_data", 64'(out_data), 64'h00);
    chk("zero_idx", 64'(out_idx), 64'd0);
    chk("zero_cnt", 64'(beat_cnt), 64'd4);
    cyc(1'b0, 5'b00000, 1'b1, 1'b1);
    chk("clr_err", 64'(err_onehot), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 5'b00011, 1'b1, 1'b1);
    chk("clr_bad_err", 64'(err_onehot), 64'd1);
    chk("clr_bad_data", 64'(out_data), 64'h33);
    chk("clr_bad_cnt", 64'(beat_cnt), 64'd5);
    cyc(1'b0, 5'b11111, 1'b1, 1'b1);
    chk("clr2_err", 64'(err_onehot), 64'd0);

    // mid-cycle reset while a beat is held
    cyc(1'b1, 5'b10000, 1'b0, 1'b0);
    chk("pre_rst_data", 64'(out_data), 64'h55);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_idx", 64'(out_idx), 64'd0);
    chk("arst_cnt", 64'(beat_cnt), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 17 back-to-back beats: counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < int'(N_CH); k++) in_data[k*W +: W] = 8'(i*8 + k);
      cyc(1'b1, 5'(1 << (i % 5)), 1'b1, 1'b0);
    end
    chk("wrap_cnt", 64'(beat_cnt), 64'd1);
    chk("wrap_last_data", 64'(out_data), 64'h81);
    chk("wrap_last_idx", 64'(out_idx), 64'd1);
    cyc(1'b0, 5'b00000, 1'b1, 1'b0);
    chk("drain_valid", 64'(out_valid), 64'd0);

`ifdef DATA_MUX_PIPE_PARITY_EN
    in_data = CH_BASE; in_data[7:0] = 8'h07;
    cyc(1'b1, 5'b00001, 1'b1, 1'b0);
    chk("par_07", 64'(out_par), 64'd1);
    in_data[7:0] = 8'h03;
    cyc(1'b1, 5'b00001, 1'b1, 1'b0);
    chk("par_03", 64'(out_par), 64'd0);
`endif

    cyc(1'b0, 5'b00000, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
